// File: rtl/cdb_arbiter.sv
// cdb_arbiter: producer end of the common data bus.
// Each execution unit hands its finished result (tag, data) to a small private
// FIFO through a valid/ready handshake. Every cycle, a round-robin arbiter picks
// at most one non-empty FIFO. It pops that FIFO's head into a registered,
// single-cycle broadcast that every reservation station and the register
// status table snoop. The bus has no backpressure, so a winner is always
// broadcast on the next edge.
// Tag 0 means "no producer". Such results are handshaken but never stored,
// so they can never appear on the bus.

module cdb_arbiter #(
   parameter int BW_PROCESSOR_DATA = 32,
   parameter int BW_TAG            = 3,
   parameter int NUM_SOURCE        = 3,
   parameter int FIFO_DEPTH        = 2
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_SOURCE-1:0]                   i_exe_valid,
   output logic [NUM_SOURCE-1:0]                   i_exe_ready,
   input  logic [NUM_SOURCE*BW_TAG-1:0]            i_exe_tag_flatten,
   input  logic [NUM_SOURCE*BW_PROCESSOR_DATA-1:0] i_exe_data_flatten,
   output logic                                    o_cdb_valid,
   output logic [BW_TAG-1:0]                       o_cdb_tag,
   output logic signed [BW_PROCESSOR_DATA-1:0]     o_cdb_data,
   output logic [$clog2(NUM_SOURCE*FIFO_DEPTH+1)-1:0] o_pending
);

   // FIFO_DEPTH is a power of two, so the read/write pointers wrap for free.
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int SRC_W  = (NUM_SOURCE > 1) ? $clog2(NUM_SOURCE) : 1;
   localparam int PEND_W = $clog2(NUM_SOURCE * FIFO_DEPTH + 1);

   // Per-source FIFO storage and bookkeeping
   logic [BW_TAG-1:0]            tag_mem  [NUM_SOURCE][FIFO_DEPTH];
   logic [BW_PROCESSOR_DATA-1:0] data_mem [NUM_SOURCE][FIFO_DEPTH];
   logic [PTR_W-1:0]             rd_ptr   [NUM_SOURCE];
   logic [PTR_W-1:0]             wr_ptr   [NUM_SOURCE];
   logic [CNT_W-1:0]             count    [NUM_SOURCE];
   logic [CNT_W-1:0]             count_next [NUM_SOURCE];

   // Unpacked views of the flattened result buses
   logic [BW_TAG-1:0]            in_tag   [NUM_SOURCE];
   logic [BW_PROCESSOR_DATA-1:0] in_data  [NUM_SOURCE];

   logic [NUM_SOURCE-1:0]        full;
   logic [NUM_SOURCE-1:0]        empty;
   logic [NUM_SOURCE-1:0]        push;
   logic [NUM_SOURCE-1:0]        pop;

   // Arbitration state
   logic                         win_valid;
   logic [SRC_W-1:0]             win_idx;
   logic [SRC_W-1:0]             rr_ptr;
   logic [SRC_W-1:0]             rr_next;
   logic [PEND_W-1:0]            pending_next;

   // Maps start+offset back into 0..NUM_SOURCE-1.
   // The sum never reaches 2*NUM_SOURCE, so one subtraction is enough.
   function automatic logic [SRC_W-1:0] wrap_src(input int val);
      if (val >= NUM_SOURCE) begin
         return SRC_W'(val - NUM_SOURCE);
      end
      return SRC_W'(val);
   endfunction

   for (genvar g = 0; g < NUM_SOURCE; g++) begin : g_src
      assign in_tag[g]  = i_exe_tag_flatten[g*BW_TAG +: BW_TAG];
      assign in_data[g] = i_exe_data_flatten[g*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
      assign full[g]    = (count[g] == CNT_W'(FIFO_DEPTH));
      assign empty[g]   = (count[g] == '0);
      // Ready depends only on occupancy. A full FIFO stays closed even when
      // it is being popped this cycle, which keeps ready off the
      // arbitration path.
      assign i_exe_ready[g] = !rst && !full[g];
      // Tag-0 results complete the handshake but are dropped here.
      assign push[g]       = i_exe_valid[g] && i_exe_ready[g] && (in_tag[g] != '0);
      assign pop[g]        = win_valid && (win_idx == SRC_W'(g));
      assign count_next[g] = count[g] + CNT_W'(push[g]) - CNT_W'(pop[g]);
   end

   // Round-robin search: first non-empty FIFO at or above the pointer, modulo NUM_SOURCE
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NUM_SOURCE; i++) begin
         if (!win_valid && !empty[wrap_src(int'(rr_ptr) + i)]) begin
            win_valid = 1'b1;
            win_idx   = wrap_src(int'(rr_ptr) + i);
         end
      end
   end

   // Next round-robin start is the source just after the winner
   always_comb begin
      rr_next = '0;
      if (win_idx != SRC_W'(NUM_SOURCE - 1)) begin
         rr_next = win_idx + SRC_W'(1);
      end
   end

   // Total occupancy after this edge, so o_pending tracks the FIFOs exactly
   always_comb begin
      pending_next = '0;
      for (int k = 0; k < NUM_SOURCE; k++) begin
         pending_next = pending_next + PEND_W'(count_next[k]);
      end
   end

   // FIFO pointers and occupancy; reset discards everything buffered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_SOURCE; k++) begin
            rd_ptr[k] <= '0;
            wr_ptr[k] <= '0;
            count[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_SOURCE; k++) begin
            if (push[k]) begin
               wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
            end
            if (pop[k]) begin
               rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
            end
            count[k] <= count_next[k];
         end
      end
   end

   // FIFO payload storage; contents are meaningless until the count covers them
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_SOURCE; k++) begin
         if (push[k]) begin
            tag_mem[k][wr_ptr[k]]  <= in_tag[k];
            data_mem[k][wr_ptr[k]] <= in_data[k];
         end
      end
   end

   // Registered broadcast, round-robin pointer and pending count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_cdb_valid <= 1'b0;
         o_cdb_tag   <= '0;
         o_cdb_data  <= '0;
         rr_ptr      <= '0;
         o_pending   <= '0;
      end else begin
         o_cdb_valid <= win_valid;
         if (win_valid) begin
            o_cdb_tag  <= tag_mem[win_idx][rd_ptr[win_idx]];
            o_cdb_data <= data_mem[win_idx][rd_ptr[win_idx]];
            rr_ptr     <= rr_next;
         end
         o_pending <= pending_next;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter with default parameters.
// Expected broadcasts go into a queue when stimulus is driven.
// A negedge monitor pops the queue on every broadcast and compares.
// Cycle-exact checks of handshake, pending count and bus timing sit inline.

module tb_cdb_arbiter;

   localparam int NS = 3;
   localparam int TW = 3;
   localparam int DW = 32;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } bcast_t;

   logic             clk;
   logic             rst;
   logic [NS-1:0]    exe_valid;
   logic [NS-1:0]    exe_ready;
   logic [NS*TW-1:0] exe_tag_flat;
   logic [NS*DW-1:0] exe_data_flat;
   logic             cdb_valid;
   logic [TW-1:0]    cdb_tag;
   logic [DW-1:0]    cdb_data;
   logic [2:0]       pending;

   bcast_t sb_q[$];
   int     assert_count = 0;
   int     fail_count   = 0;

   cdb_arbiter #(
      .BW_PROCESSOR_DATA (DW),
      .BW_TAG            (TW),
      .NUM_SOURCE        (NS),
      .FIFO_DEPTH        (2)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .i_exe_valid        (exe_valid),
      .i_exe_ready        (exe_ready),
      .i_exe_tag_flatten  (exe_tag_flat),
      .i_exe_data_flatten (exe_data_flat),
      .o_cdb_valid        (cdb_valid),
      .o_cdb_tag          (cdb_tag),
      .o_cdb_data         (cdb_data),
      .o_pending          (pending)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int k, input logic v, input logic [TW-1:0] tag,
                                input logic [DW-1:0] data);
      exe_valid[k]             = v;
      exe_tag_flat[k*TW +: TW] = tag;
      exe_data_flat[k*DW +: DW] = data;
   endtask

   task automatic pushExpected(input logic [TW-1:0] tag, input logic [DW-1:0] data);
      bcast_t e;
      e.tag  = tag;
      e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain(input string name);
      for (int c = 0; c < 40 && sb_q.size() != 0; c++) @(posedge clk);
      #1;
      checkOutput(name, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic doReset();
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_ready", 32'(exe_ready), 32'd0);
      checkOutput("rst_valid", 32'(cdb_valid), 32'd0);
      checkOutput("rst_pending", 32'(pending), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      nextEdge();
   endtask

   // Scoreboard monitor: every broadcast must match the oldest expected entry
   always @(negedge clk) begin
      if (cdb_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_bcast", 32'(cdb_valid), 32'd0);
         end else begin
            bcast_t e;
            e = sb_q.pop_front();
            checkOutput("sb_tag", 32'(cdb_tag), 32'(e.tag));
            checkOutput("sb_data", cdb_data, e.data);
         end
      end
   end

   // Watchdog so the bench always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int  seq0;
      int  seq2;
      bit  hs0;
      bit  hs2;

      rst           = 1'b0;
      exe_valid     = '0;
      exe_tag_flat  = '0;
      exe_data_flat = '0;

      // Reset state
      doReset();
      checkOutput("post_rst_ready", 32'(exe_ready), 32'h7);
      checkOutput("post_rst_tag", 32'(cdb_tag), 32'd0);
      checkOutput("post_rst_data", cdb_data, 32'd0);
      $display("[TB] reset checks done");

      // Single result from source 1
      applyStimulus(1, 1'b1, 3'd5, -7);
      pushExpected(3'd5, -7);
      nextEdge();
      checkOutput("s1_pending_1", 32'(pending), 32'd1);
      checkOutput("s1_valid_e1", 32'(cdb_valid), 32'd0);
      applyStimulus(1, 1'b0, 3'd0, 32'd0);
      nextEdge();
      checkOutput("s1_valid_e2", 32'(cdb_valid), 32'd1);
      checkOutput("s1_tag_e2", 32'(cdb_tag), 32'd5);
      checkOutput("s1_data_e2", cdb_data, -7);
      checkOutput("s1_pending_0", 32'(pending), 32'd0);
      nextEdge();
      checkOutput("s1_valid_e3", 32'(cdb_valid), 32'd0);
      checkOutput("s1_tag_hold", 32'(cdb_tag), 32'd5);
      waitDrain("s1_drain");
      $display("[TB] single result done");

      // Simultaneous push on all sources with the pointer at 0
      doReset();
      applyStimulus(0, 1'b1, 3'd1, 32'd100);
      applyStimulus(1, 1'b1, 3'd2, 32'd200);
      applyStimulus(2, 1'b1, 3'd3, 32'd300);
      pushExpected(3'd1, 32'd100);
      pushExpected(3'd2, 32'd200);
      pushExpected(3'd3, 32'd300);
      nextEdge();
      for (int k = 0; k < NS; k++) applyStimulus(k, 1'b0, 3'd0, 32'd0);
      checkOutput("s2_pending_3", 32'(pending), 32'd3);
      checkOutput("s2_valid_e1", 32'(cdb_valid), 32'd0);
      nextEdge();
      checkOutput("s2_tag_e2", 32'(cdb_tag), 32'd1);
      checkOutput("s2_pending_2", 32'(pending), 32'd2);
      nextEdge();
      checkOutput("s2_tag_e3", 32'(cdb_tag), 32'd2);
      nextEdge();
      checkOutput("s2_tag_e4", 32'(cdb_tag), 32'd3);
      checkOutput("s2_pending_0", 32'(pending), 32'd0);
      nextEdge();
      checkOutput("s2_valid_e5", 32'(cdb_valid), 32'd0);
      waitDrain("s2_drain");
      $display("[TB] simultaneous push done");

      // Fairness and FIFO wrap: sources 0 and 2 held valid, broadcasts alternate
      for (int j = 0; j < 8; j++) begin
         pushExpected(3'd4, 32'(1000 + j));
         pushExpected(3'd6, 32'(2000 + j));
      end
      seq0 = 0;
      seq2 = 0;
      applyStimulus(0, 1'b1, 3'd4, 32'd1000);
      applyStimulus(2, 1'b1, 3'd6, 32'd2000);
      for (int c = 0; c < 100 && !(seq0 == 8 && seq2 == 8); c++) begin
         hs0 = exe_valid[0] && exe_ready[0];
         hs2 = exe_valid[2] && exe_ready[2];
         nextEdge();
         if (hs0) seq0++;
         if (hs2) seq2++;
         if (seq0 < 8) applyStimulus(0, 1'b1, 3'd4, 32'(1000 + seq0));
         else          applyStimulus(0, 1'b0, 3'd0, 32'd0);
         if (seq2 < 8) applyStimulus(2, 1'b1, 3'd6, 32'(2000 + seq2));
         else          applyStimulus(2, 1'b0, 3'd0, 32'd0);
      end
      checkOutput("s3_accepted0", 32'(seq0), 32'd8);
      checkOutput("s3_accepted2", 32'(seq2), 32'd8);
      waitDrain("s3_drain");
      $display("[TB] fairness done");

      // Backpressure: move the pointer to 1, then overfill source 0
      applyStimulus(0, 1'b1, 3'd4, 32'd55);
      pushExpected(3'd4, 32'd55);
      nextEdge();
      applyStimulus(0, 1'b0, 3'd0, 32'd0);
      waitDrain("s4_pre_drain");
      pushExpected(3'd2, 32'd201);
      pushExpected(3'd3, 32'd301);
      pushExpected(3'd1, 32'd101);
      pushExpected(3'd2, 32'd202);
      pushExpected(3'd3, 32'd302);
      pushExpected(3'd1, 32'd102);
      pushExpected(3'd1, 32'd103);
      applyStimulus(0, 1'b1, 3'd1, 32'd101);
      applyStimulus(1, 1'b1, 3'd2, 32'd201);
      applyStimulus(2, 1'b1, 3'd3, 32'd301);
      nextEdge();
      checkOutput("s4_ready0_f1", 32'(exe_ready[0]), 32'd1);
      applyStimulus(0, 1'b1, 3'd1, 32'd102);
      applyStimulus(1, 1'b1, 3'd2, 32'd202);
      applyStimulus(2, 1'b1, 3'd3, 32'd302);
      nextEdge();
      checkOutput("s4_ready0_f2", 32'(exe_ready[0]), 32'd0);
      checkOutput("s4_tag_f2", 32'(cdb_tag), 32'd2);
      applyStimulus(0, 1'b1, 3'd1, 32'd103);
      applyStimulus(1, 1'b0, 3'd0, 32'd0);
      applyStimulus(2, 1'b0, 3'd0, 32'd0);
      nextEdge();
      checkOutput("s4_ready0_f3", 32'(exe_ready[0]), 32'd0);
      checkOutput("s4_tag_f3", 32'(cdb_tag), 32'd3);
      nextEdge();
      checkOutput("s4_tag_f4", 32'(cdb_tag), 32'd1);
      checkOutput("s4_data_f4", cdb_data, 32'd101);
      checkOutput("s4_ready0_f4", 32'(exe_ready[0]), 32'd1);
      nextEdge();
      applyStimulus(0, 1'b0, 3'd0, 32'd0);
      checkOutput("s4_pending_f5", 32'(pending), 32'd3);
      waitDrain("s4_drain");
      $display("[TB] backpressure done");

      // Tag zero: handshake completes but nothing is stored or broadcast
      applyStimulus(2, 1'b1, 3'd0, 32'd99);
      #1;
      checkOutput("s5_ready2", 32'(exe_ready[2]), 32'd1);
      nextEdge();
      applyStimulus(2, 1'b0, 3'd0, 32'd0);
      checkOutput("s5_pending", 32'(pending), 32'd0);
      repeat (3) nextEdge();
      checkOutput("s5_valid", 32'(cdb_valid), 32'd0);
      checkOutput("s5_pending_late", 32'(pending), 32'd0);
      $display("[TB] tag zero done");

      // Reset mid-operation with four entries buffered (pointer is 1 here)
      applyStimulus(0, 1'b1, 3'd1, 32'd11);
      applyStimulus(1, 1'b1, 3'd2, 32'd22);
      applyStimulus(2, 1'b1, 3'd3, 32'd33);
      nextEdge();
      applyStimulus(0, 1'b1, 3'd1, 32'd12);
      applyStimulus(1, 1'b0, 3'd0, 32'd0);
      applyStimulus(2, 1'b1, 3'd3, 32'd34);
      nextEdge();
      for (int k = 0; k < NS; k++) applyStimulus(k, 1'b0, 3'd0, 32'd0);
      checkOutput("s6_pending_4", 32'(pending), 32'd4);
      checkOutput("s6_tag_g2", 32'(cdb_tag), 32'd2);
      #1 rst = 1'b1;
      #1;
      checkOutput("s6_rst_valid", 32'(cdb_valid), 32'd0);
      checkOutput("s6_rst_tag", 32'(cdb_tag), 32'd0);
      checkOutput("s6_rst_data", cdb_data, 32'd0);
      checkOutput("s6_rst_pending", 32'(pending), 32'd0);
      checkOutput("s6_rst_ready", 32'(exe_ready), 32'd0);
      repeat (2) nextEdge();
      checkOutput("s6_rst_ready_held", 32'(exe_ready), 32'd0);
      #2 rst = 1'b0;
      repeat (4) nextEdge();
      checkOutput("s6_after_valid", 32'(cdb_valid), 32'd0);
      checkOutput("s6_after_pending", 32'(pending), 32'd0);
      applyStimulus(1, 1'b1, 3'd7, 32'd777);
      pushExpected(3'd7, 32'd777);
      nextEdge();
      applyStimulus(1, 1'b0, 3'd0, 32'd0);
      nextEdge();
      checkOutput("s6_new_valid", 32'(cdb_valid), 32'd1);
      checkOutput("s6_new_tag", 32'(cdb_tag), 32'd7);
      checkOutput("s6_new_data", cdb_data, 32'd777);
      waitDrain("s6_drain");
      $display("[TB] reset mid-operation done");

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Producer end of the common data bus. Collects completed results (tag, data) from NUM_SOURCE execution units over valid/ready handshakes and buffers them in per-source FIFOs. Round-robin arbitration picks at most one result per cycle and drives it as a registered one-cycle broadcast that all reservation stations and the register status table snoop. Sits between the execution units' result ports and the CDB consumers.

Parameters:
BW_PROCESSOR_DATA, 32, width of result data
BW_TAG, 3, tag width; tag 0 means "no producer" and is never broadcast
NUM_SOURCE, 3, number of execution units feeding the bus (>=2)
FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_exe_valid  input  NUM_SOURCE  per-source result valid
i_exe_ready  output  NUM_SOURCE  per-source ready, 1 = FIFO has space
i_exe_tag_flatten  input  NUM_SOURCE*BW_TAG  source k tag at [k*BW_TAG +: BW_TAG]
i_exe_data_flatten  input  NUM_SOURCE*BW_PROCESSOR_DATA  source k data, same slicing; signed
o_cdb_valid  output  1  broadcast valid, high for exactly one cycle per result
o_cdb_tag  output  BW_TAG  broadcast tag
o_cdb_data  output  BW_PROCESSOR_DATA  broadcast data, signed
o_pending  output  $clog2(NUM_SOURCE*FIFO_DEPTH+1)  total buffered entries

Behaviour:
- Reset (async, rst=1): all FIFOs empty, RR pointer=0, o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, o_pending=0, i_exe_ready=0 while rst is high. Asserting rst mid-operation drops all buffered results.
- i_exe_ready[k] = !rst && !full[k]. It is independent of i_exe_valid and of the same-cycle pop. A full FIFO does not accept a push even when it is popped that cycle.
- Push on source k at an edge where i_exe_valid[k] && i_exe_ready[k]. Entries with tag 0 are handshaken (ready honoured) but not written, and are never broadcast.
- Arbitration (combinational, from FIFO heads): the candidate set is the non-empty FIFOs. Search starts at the RR pointer and proceeds upward modulo NUM_SOURCE. The first hit wins.
- On the edge after a win: the winner's head is popped and registered into o_cdb_tag/o_cdb_data with o_cdb_valid=1, and pointer=(winner+1) mod NUM_SOURCE. With no candidate: o_cdb_valid=0, tag and data hold their last value, pointer unchanged.
- Latency: a result accepted at edge E is visible on the CDB from edge E+1 at the earliest. Throughput is one broadcast per cycle. The CDB has no backpressure.
- Order within a source is FIFO order. Between sources the arbiter is fair: with all sources continuously non-empty, each source wins once every NUM_SOURCE cycles.
- Push and pop on the same non-full FIFO in the same cycle: occupancy is unchanged, and the head advances correctly. This also covers DEPTH-1 occupancy and wrap of the read/write pointers (mod FIFO_DEPTH).
- o_pending = sum of FIFO occupancies, registered, updated every cycle: +pushes, -1 on a pop.
- Each buffered tag is broadcast exactly once. No duplication, no loss except on reset.

Test Plan:
- Single result: source1 pushes tag=5, data=-7 at edge 1 -> o_cdb_valid=1, tag=5, data=-7 between edges 2 and 3, then 0. o_pending goes 1 then 0.
- Simultaneous push: sources 0,1,2 push tags 1,2,3 at edge 1 with pointer=0 -> broadcasts 1,2,3 on three consecutive cycles, pointer ends at 0.
- Fairness and wrap: source0 and source2 held valid continuously with tags 4 and 6 -> broadcasts alternate 4,6,4,6. Source0 order is preserved across FIFO pointer wrap.
- Backpressure: source0 pushes 3 results back-to-back (DEPTH=2) while source1 and source2 keep winning -> i_exe_ready[0]=0 once full. The third result is accepted only after a pop, and all three are broadcast in order.
- Tag zero: source2 pushes tag=0, data=99 -> handshake completes, no broadcast, o_pending stays 0.
- Reset mid-operation: 4 entries buffered, rst pulsed asynchronously between edges -> outputs immediately 0, i_exe_ready=0 during rst. After release there are no broadcasts, and a new push of tag=7 broadcasts normally.
